// File: rtl/ysyx_22040750_clint_arb.sv
// Two-master round-robin arbiter and sequencer for the CLINT mtime/mtimecmp port.
// One transaction in flight: accept (IDLE) -> single CLINT cycle (ACCESS) -> response (RESP).
module ysyx_22040750_clint_arb #(
  parameter logic [31:0] BASE_ADDR     = 32'h0200_0000,
  parameter logic [31:0] MTIMECMP_ADDR = 32'h0000_4000 + BASE_ADDR,
  parameter logic [31:0] MTIME_ADDR    = 32'h0000_BFF8 + BASE_ADDR
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_m0_valid,
  output logic        O_m0_ready,
  input  logic [31:0] I_m0_addr,
  input  logic        I_m0_wen,
  input  logic [63:0] I_m0_wdata,
  output logic        O_m0_rvalid,
  input  logic        I_m0_rready,
  output logic [63:0] O_m0_rdata,
  output logic        O_m0_err,
  input  logic        I_m1_valid,
  output logic        O_m1_ready,
  input  logic [31:0] I_m1_addr,
  input  logic        I_m1_wen,
  input  logic [63:0] I_m1_wdata,
  output logic        O_m1_rvalid,
  input  logic        I_m1_rready,
  output logic [63:0] O_m1_rdata,
  output logic        O_m1_err,
  output logic [31:0] O_clint_addr,
  output logic        O_clint_wr_en,
  output logic [63:0] O_clint_wr_data,
  input  logic [63:0] I_clint_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e      state_r;
  logic        last_grant_r;
  logic        lat_id_r;
  logic        lat_wen_r;
  logic [31:0] clint_addr_r;
  logic [63:0] clint_wr_data_r;
  logic        clint_wr_en_r;
  logic [63:0] rdata_r;
  logic [1:0]  rvalid_r;
  logic [1:0]  err_r;

  logic        grant_vld_s;
  logic        grant_id_s;
  logic [31:0] sel_addr_s;
  logic        sel_wen_s;
  logic [63:0] sel_wdata_s;
  logic        sel_rready_s;

  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr == MTIME_ADDR) || (addr == MTIMECMP_ADDR);
  endfunction

  // Round-robin grant: on contention the master that did not win last time goes first.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (state_r == S_IDLE) begin
      case ({I_m1_valid, I_m0_valid})
        2'b01: begin
          grant_vld_s = 1'b1;
          grant_id_s  = 1'b0;
        end
        2'b10: begin
          grant_vld_s = 1'b1;
          grant_id_s  = 1'b1;
        end
        2'b11: begin
          grant_vld_s = 1'b1;
          grant_id_s  = ~last_grant_r;
        end
        default: begin
          grant_vld_s = 1'b0;
          grant_id_s  = 1'b0;
        end
      endcase
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Request and response-handshake mux for the granted / latched master.
  always_comb begin
    sel_addr_s   = I_m0_addr;
    sel_wen_s    = I_m0_wen;
    sel_wdata_s  = I_m0_wdata;
    sel_rready_s = I_m0_rready;
    if (grant_id_s) begin
      sel_addr_s  = I_m1_addr;
      sel_wen_s   = I_m1_wen;
      sel_wdata_s = I_m1_wdata;
    end else begin
      sel_addr_s  = I_m0_addr;
      sel_wen_s   = I_m0_wen;
      sel_wdata_s = I_m0_wdata;
    end
    if (lat_id_r) begin
      sel_rready_s = I_m1_rready;
    end else begin
      sel_rready_s = I_m0_rready;
    end
  end

  // Transaction sequencer; wr_en is set at accept so it is high for the ACCESS cycle only.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r         <= S_IDLE;
      last_grant_r    <= 1'b1;
      lat_id_r        <= 1'b0;
      lat_wen_r       <= 1'b0;
      clint_addr_r    <= 32'd0;
      clint_wr_data_r <= 64'd0;
      clint_wr_en_r   <= 1'b0;
      rdata_r         <= 64'd0;
      rvalid_r        <= 2'b00;
      err_r           <= 2'b00;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (grant_vld_s) begin
            lat_id_r        <= grant_id_s;
            last_grant_r    <= grant_id_s;
            lat_wen_r       <= sel_wen_s;
            clint_addr_r    <= sel_addr_s;
            clint_wr_data_r <= sel_wdata_s;
            clint_wr_en_r   <= sel_wen_s & addr_legal(sel_addr_s);
            state_r         <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          clint_wr_en_r <= 1'b0;
          rvalid_r      <= lat_id_r ? 2'b10 : 2'b01;
          if (addr_legal(clint_addr_r)) begin
            rdata_r <= lat_wen_r ? 64'd0 : I_clint_rd_data;
            err_r   <= 2'b00;
          end else begin
            rdata_r <= 64'd0;
            err_r   <= lat_id_r ? 2'b10 : 2'b01;
          end
          state_r <= S_RESP;
        end
        S_RESP: begin
          if (sel_rready_s) begin
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
            state_r  <= S_IDLE;
          end
        end
        default: begin
          clint_wr_en_r <= 1'b0;
          rvalid_r      <= 2'b00;
          err_r         <= 2'b00;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

  assign O_m0_ready      = grant_vld_s & ~grant_id_s;
  assign O_m1_ready      = grant_vld_s & grant_id_s;
  assign O_m0_rvalid     = rvalid_r[0];
  assign O_m1_rvalid     = rvalid_r[1];
  assign O_m0_err        = err_r[0];
  assign O_m1_err        = err_r[1];
  assign O_m0_rdata      = rdata_r;
  assign O_m1_rdata      = rdata_r;
  assign O_clint_addr    = clint_addr_r;
  assign O_clint_wr_en   = clint_wr_en_r;
  assign O_clint_wr_data = clint_wr_data_r;

endmodule

// File: tb/tb_ysyx_22040750_clint_arb.sv
// Directed plus randomized bench for the CLINT arbiter, with a small CLINT model
// and a transaction-level reference for grant order, read data and errors.
module tb_ysyx_22040750_clint_arb;

  localparam logic [31:0] BASE     = 32'h0200_0000;
  localparam logic [31:0] MTIMECMP = 32'h0200_4000;
  localparam logic [31:0] MTIME    = 32'h0200_BFF8;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic [1:0]  mv = 2'b00;
  logic [1:0]  mrr = 2'b00;
  logic [1:0]  mwen = 2'b00;
  logic [31:0] maddr [2];
  logic [63:0] mwd [2];
  wire  [1:0]  mready;
  wire  [1:0]  mrvalid;
  wire  [1:0]  merr;
  wire  [63:0] m0_rdata;
  wire  [63:0] m1_rdata;
  wire  [31:0] clint_addr;
  wire         clint_wr_en;
  wire  [63:0] clint_wr_data;
  wire  [63:0] clint_rd_data;

  logic [63:0] clint_mtime = 64'h0000_0000_0000_1000;
  logic [63:0] clint_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [63:0] cmp_shadow  = 64'hFFFF_FFFF_FFFF_FFFF;
  int          wr_pulses = 0;
  int          errors = 0;
  int          checks = 0;
  bit          last_exp = 1'b1;
  bit          g;

  ysyx_22040750_clint_arb dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_m0_valid(mv[0]), .O_m0_ready(mready[0]), .I_m0_addr(maddr[0]),
    .I_m0_wen(mwen[0]), .I_m0_wdata(mwd[0]), .O_m0_rvalid(mrvalid[0]),
    .I_m0_rready(mrr[0]), .O_m0_rdata(m0_rdata), .O_m0_err(merr[0]),
    .I_m1_valid(mv[1]), .O_m1_ready(mready[1]), .I_m1_addr(maddr[1]),
    .I_m1_wen(mwen[1]), .I_m1_wdata(mwd[1]), .O_m1_rvalid(mrvalid[1]),
    .I_m1_rready(mrr[1]), .O_m1_rdata(m1_rdata), .O_m1_err(merr[1]),
    .O_clint_addr(clint_addr), .O_clint_wr_en(clint_wr_en),
    .O_clint_wr_data(clint_wr_data), .I_clint_rd_data(clint_rd_data)
  );

  always #5 I_clk = ~I_clk;

  // CLINT model: combinational read, write on posedge, mtime ticks every cycle
  assign clint_rd_data = (clint_addr == MTIME) ? clint_mtime :
                         (clint_addr == MTIMECMP) ? clint_cmp : 64'd0;

  always @(posedge I_clk) begin
    if (clint_wr_en && clint_addr == MTIMECMP) clint_cmp <= clint_wr_data;
    if (clint_wr_en && clint_addr == MTIME) clint_mtime <= clint_wr_data;
    else clint_mtime <= clint_mtime + 64'd1;
  end

  always @(negedge I_clk) begin
    if (clint_wr_en) wr_pulses <= wr_pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rdata_of(input bit m);
    return m ? m1_rdata : m0_rdata;
  endfunction

  task automatic req(input bit m, input logic [31:0] a, input logic w, input logic [63:0] d);
    maddr[m] = a;
    mwen[m]  = w;
    mwd[m]   = d;
    mv[m]    = 1'b1;
  endtask

  // One full transaction for whichever master the round-robin rule says must win.
  task automatic run_txn(input int hold, input bit rst_in_access, output bit gid);
    bit          exp_m;
    bit          legal;
    int          n;
    int          pulses0;
    logic [31:0] a;
    logic        w;
    logic [63:0] d;
    logic [63:0] exp_rdata;
    logic [1:0]  onehot;
    exp_m  = (mv == 2'b11) ? ~last_exp : mv[1];
    gid    = exp_m;
    onehot = exp_m ? 2'b10 : 2'b01;
    n = 0;
    do begin
      @(negedge I_clk);
      n++;
    end while (!(|(mready & mv)) && n < 20);
    chk("grant", {62'd0, mready}, {62'd0, onehot});
    if (!(|(mready & mv))) return;
    a = maddr[exp_m];
    w = mwen[exp_m];
    d = mwd[exp_m];
    legal = (a == MTIME) || (a == MTIMECMP);
    pulses0 = wr_pulses;
    @(posedge I_clk); #1;
    mv[exp_m] = 1'b0;
    last_exp  = exp_m;
    @(negedge I_clk);
    chk("acc_addr", {32'd0, clint_addr}, {32'd0, a});
    chk("acc_wen", {63'd0, clint_wr_en}, {63'd0, w && legal});
    chk("acc_wdata", clint_wr_data, d);
    chk("acc_ready", {62'd0, mready}, 64'd0);
    if (!legal || w) exp_rdata = 64'd0;
    else if (a == MTIME) exp_rdata = clint_mtime;
    else exp_rdata = cmp_shadow;
    if (rst_in_access) begin
      I_rst_n = 1'b0;
      #1;
      chk("rst_wen", {63'd0, clint_wr_en}, 64'd0);
      chk("rst_addr", {32'd0, clint_addr}, 64'd0);
      chk("rst_wdata", clint_wr_data, 64'd0);
      chk("rst_rvalid", {62'd0, mrvalid}, 64'd0);
      chk("rst_ready", {62'd0, mready}, 64'd0);
      @(posedge I_clk); #1;
      I_rst_n  = 1'b1;
      last_exp = 1'b1;
      chk("rst_no_write", clint_cmp, cmp_shadow);
      return;
    end
    if (legal && w && a == MTIMECMP) cmp_shadow = d;
    @(posedge I_clk);
    @(negedge I_clk);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        @(posedge I_clk);
        @(negedge I_clk);
      end
      chk("rvalid", {62'd0, mrvalid}, {62'd0, onehot});
      chk("rdata", rdata_of(exp_m), exp_rdata);
      chk("err", {62'd0, merr}, legal ? 64'd0 : {62'd0, onehot});
      chk("busy_ready", {62'd0, mready}, 64'd0);
    end
    chk("wr_pulses", 64'(wr_pulses - pulses0), (w && legal) ? 64'd1 : 64'd0);
    mrr[exp_m] = 1'b1;
    @(posedge I_clk); #1;
    mrr[exp_m] = 1'b0;
    chk("rvalid_clr", {62'd0, mrvalid}, 64'd0);
    chk("err_clr", {62'd0, merr}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  mask;
    for (int i = 0; i < 2; i++) begin
      maddr[i] = 32'd0;
      mwd[i]   = 64'd0;
    end
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    chk("reset_ready", {62'd0, mready}, 64'd0);
    chk("reset_rvalid", {62'd0, mrvalid}, 64'd0);
    chk("reset_err", {62'd0, merr}, 64'd0);
    chk("reset_wen", {63'd0, clint_wr_en}, 64'd0);
    chk("reset_addr", {32'd0, clint_addr}, 64'd0);
    chk("reset_wdata", clint_wr_data, 64'd0);
    chk("reset_rdata", m0_rdata, 64'd0);
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;

    // contention straight after reset: M0, M1, M0, M1
    req(1'b0, MTIMECMP, 1'b0, 64'd0);
    req(1'b1, MTIME, 1'b0, 64'd0);
    run_txn(0, 1'b0, g); chk("arb_1st", {63'd0, g}, 64'd0);
    req(1'b0, MTIME, 1'b0, 64'd0);
    run_txn(0, 1'b0, g); chk("arb_2nd", {63'd0, g}, 64'd1);
    req(1'b1, MTIMECMP, 1'b0, 64'd0);
    run_txn(0, 1'b0, g); chk("arb_3rd", {63'd0, g}, 64'd0);
    run_txn(0, 1'b0, g); chk("arb_4th", {63'd0, g}, 64'd1);

    // write then read back mtimecmp
    req(1'b0, MTIMECMP, 1'b1, 64'h100);
    run_txn(0, 1'b0, g);
    req(1'b0, MTIMECMP, 1'b0, 64'd0);
    run_txn(1, 1'b0, g);

    // M1 reads mtime after the timer has ticked
    repeat (7) @(posedge I_clk); #1;
    req(1'b1, MTIME, 1'b0, 64'd0);
    run_txn(0, 1'b0, g);

    // M0 wins after M1, response held 5 cycles with M1 waiting
    req(1'b0, MTIMECMP, 1'b0, 64'd0);
    req(1'b1, MTIME, 1'b0, 64'd0);
    run_txn(5, 1'b0, g); chk("hold_grant", {63'd0, g}, 64'd0);
    run_txn(0, 1'b0, g);

    // decode error on a write
    req(1'b0, BASE + 32'h10, 1'b1, 64'h1234_5678_9ABC_DEF0);
    run_txn(0, 1'b0, g);

    // reset during the ACCESS cycle of a write
    req(1'b0, MTIMECMP, 1'b1, 64'hDEAD_BEEF_0000_0001);
    run_txn(0, 1'b1, g);
    req(1'b0, MTIMECMP, 1'b0, 64'd0);
    run_txn(0, 1'b0, g);

    for (int it = 0; it < 40; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        if (mask[m]) begin
          case ($urandom_range(0, 3))
            0: a = MTIME;
            1: a = MTIMECMP;
            2: a = BASE + ($urandom & 32'h0000_FFF8);
            default: a = $urandom;
          endcase
          req(m[0], a, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end
      end
      while (mv != 2'b00) run_txn($urandom_range(0, 3), 1'b0, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
